// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-output synchronous FIFO and serializes each byte as UART 8N1, LSB first.
// Latency: start bit begins 3 cycles after the FIFO goes non-empty; frame period 10*CLKS_PER_BIT+3 cycles (11* with parity).
// Backpressure: one FIFO read per frame, issued only from IDLE with empty low; i_Tx_Enable low holds off new frames but never truncates one.
//
// Optional feature: define UART_TX_PARITY_EN to send an even-parity bit between bit 7 and the stop bit (8E1).
//
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset        asynchronous active-low reset
//   i_Tx_Enable    allow new frames to start
//   i_Fifo_Empty   FIFO empty flag (registered in the FIFO)
//   i_Fifo_Data    FIFO read data, valid the cycle after o_Fifo_Read_En
//   o_Fifo_Read_En FIFO read enable, one cycle per frame
//   o_Tx_Serial    UART line, idle high
//   o_Tx_Active    high from FETCH through the end of STOP
//   o_Tx_Done      one-cycle pulse in the last cycle of the stop bit

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 208
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Tx_Enable,
    input  logic       i_Fifo_Empty,
    input  logic [7:0] i_Fifo_Data,
    output logic       o_Fifo_Read_En,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        r_State;
    logic [CW-1:0] r_Clk_Cnt;
    logic [2:0]    r_Bit_Idx;
    logic [7:0]    r_Shift;
`ifdef UART_TX_PARITY_EN
    logic          r_Parity;
`endif

    logic w_Bit_End;

    assign w_Bit_End = (r_Clk_Cnt == LAST_CNT);

    // The line value for the next bit is registered on the same edge that
    // enters the state carrying it, so o_Tx_Serial changes exactly at bit
    // boundaries without any combinational path from the inputs.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State        <= S_IDLE;
            r_Clk_Cnt      <= '0;
            r_Bit_Idx      <= '0;
            r_Shift        <= '0;
`ifdef UART_TX_PARITY_EN
            r_Parity       <= 1'b0;
`endif
            o_Fifo_Read_En <= 1'b0;
            o_Tx_Serial    <= 1'b1;
            o_Tx_Active    <= 1'b0;
            o_Tx_Done      <= 1'b0;
        end else begin
            o_Fifo_Read_En <= 1'b0;
            o_Tx_Done      <= 1'b0;

            case (r_State)
                S_IDLE: begin
                    r_Clk_Cnt   <= '0;
                    o_Tx_Serial <= 1'b1;
                    // Empty is only looked at here, so a read is never issued
                    // against an empty FIFO.
                    if (i_Tx_Enable && !i_Fifo_Empty) begin
                        r_State        <= S_FETCH;
                        o_Fifo_Read_En <= 1'b1;
                        o_Tx_Active    <= 1'b1;
                    end
                end

                S_FETCH: begin
                    r_Clk_Cnt <= '0;
                    r_State   <= S_LOAD;
                end

                S_LOAD: begin
                    // FIFO data is valid now, one cycle after the read enable.
                    r_Shift     <= i_Fifo_Data;
`ifdef UART_TX_PARITY_EN
                    r_Parity    <= 1'b0;
`endif
                    r_Clk_Cnt   <= '0;
                    r_Bit_Idx   <= '0;
                    r_State     <= S_START;
                    o_Tx_Serial <= 1'b0;
                end

                S_START: begin
                    if (w_Bit_End) begin
                        r_Clk_Cnt   <= '0;
                        r_State     <= S_DATA;
                        o_Tx_Serial <= r_Shift[0];
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_Bit_End) begin
                        r_Clk_Cnt <= '0;
                        r_Bit_Idx <= r_Bit_Idx + 3'd1;
                        r_Shift   <= {1'b0, r_Shift[7:1]};
`ifdef UART_TX_PARITY_EN
                        r_Parity  <= r_Parity ^ r_Shift[0];
`endif
                        if (r_Bit_Idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            // Fold in bit 7 here since the accumulator
                            // only updates on this same edge.
                            r_State     <= S_PARITY;
                            o_Tx_Serial <= r_Parity ^ r_Shift[0];
`else
                            r_State     <= S_STOP;
                            o_Tx_Serial <= 1'b1;
`endif
                        end else begin
                            o_Tx_Serial <= r_Shift[1];
                        end
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_Bit_End) begin
                        r_Clk_Cnt   <= '0;
                        r_State     <= S_STOP;
                        o_Tx_Serial <= 1'b1;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    o_Tx_Serial <= 1'b1;
                    // Registered one cycle early so the pulse lands in the
                    // final stop-bit cycle.
                    o_Tx_Done   <= (r_Clk_Cnt == DONE_CNT);
                    if (w_Bit_End) begin
                        r_Clk_Cnt   <= '0;
                        r_State     <= S_IDLE;
                        o_Tx_Active <= 1'b0;
                    end else begin
                        r_Clk_Cnt <= r_Clk_Cnt + 1'b1;
                    end
                end

                default: begin
                    r_Clk_Cnt   <= '0;
                    r_State     <= S_IDLE;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a behavioural 1-cycle-latency FIFO and decodes the UART line.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL    = FB * CPB;
    localparam int LOG_N = 8192;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       tx_en      = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       rd_en;
    logic       tx_serial;
    logic       tx_active;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural FIFO: registered data and registered empty flag.
    logic [7:0] mem [0:255];
    int         wr_ptr    = 0;
    int         rd_ptr    = 0;
    int         rd_next   = 0;
    int         underflow = 0;

    logic [7:0] exp_q [$];

    logic line_log  [0:LOG_N-1];
    logic rd_log    [0:LOG_N-1];
    logic done_log  [0:LOG_N-1];
    logic act_log   [0:LOG_N-1];
    logic empty_log [0:LOG_N-1];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Reset        (rst_n),
        .i_Tx_Enable    (tx_en),
        .i_Fifo_Empty   (fifo_empty),
        .i_Fifo_Data    (fifo_data),
        .o_Fifo_Read_En (rd_en),
        .o_Tx_Serial    (tx_serial),
        .o_Tx_Active    (tx_active),
        .o_Tx_Done      (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_next = rd_ptr;
        if (rd_en === 1'b1) begin
            if (rd_ptr == wr_ptr) begin
                underflow <= underflow + 1;
            end else begin
                fifo_data <= mem[rd_ptr % 256];
                rd_next   = rd_ptr + 1;
            end
        end
        rd_ptr     <= rd_next;
        fifo_empty <= (rd_next == wr_ptr);
    end

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            line_log[cyc]  = tx_serial;
            rd_log[cyc]    = rd_en;
            done_log[cyc]  = tx_done;
            act_log[cyc]   = tx_active;
            empty_log[cyc] = fifo_empty;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    task automatic wait_line_low(input int bound, output int s);
        s = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                s = cyc;
                break;
            end
        end
    endtask

    function automatic int find_start(input int from, input int to);
        for (int k = from; k < to; k++)
            if (k > 0 && k < LOG_N && line_log[k] === 1'b0 && line_log[k-1] === 1'b1)
                return k;
        return -1;
    endfunction

    // Samples the middle of each data bit of a frame whose start bit begins at s.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = line_log[s + CPB*(i+1) + CPB/2];
        return b;
    endfunction

    // Expected line level for frame bit i of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && FB == 11) return ^b;
        return 1'b1;
    endfunction

    function automatic int count_rd(input int from, input int to);
        int n = 0;
        for (int k = from; k < to; k++)
            if (k >= 0 && k < LOG_N && rd_log[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_done(input int from, input int to);
        int n = 0;
        for (int k = from; k < to; k++)
            if (k >= 0 && k < LOG_N && done_log[k] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tx_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b1 || rd_en !== 1'b0 || tx_active !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state serial=%b rd=%b active=%b done=%b required 1 0 0 0",
                     tx_serial, rd_en, tx_active, tx_done);
        end
        rst_n = 1'b1;
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (tx_serial !== 1'b1 || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d serial=%b rd=%b required 1 0", i, tx_serial, rd_en);
            end
        end
    endtask

    task automatic test_single;
        int t0, k, s;
        logic [7:0] eb;
        @(negedge clk);
        t0 = cyc;
        push_byte(8'hA5);
        repeat (FL + 12) @(negedge clk);
        k = -1;
        for (int i = t0; i < t0 + 6; i++) if (k < 0 && empty_log[i] === 1'b0) k = i;
        checks++;
        if (k < 0) begin
            errors++;
            $display("FAIL single_empty_fall no falling empty seen, required within 6 cycles");
            k = t0 + 1;
        end
        s = find_start(t0, t0 + 20);
        checks++;
        if (s != k + 3) begin
            errors++;
            $display("FAIL single_start_latency start=%0d required %0d", s, k + 3);
        end
        if (s < 0) s = k + 3;
        checks++;
        if (count_rd(t0, cyc) != 1 || rd_log[k+1] !== 1'b1) begin
            errors++;
            $display("FAIL single_read_pulse count=%0d at_fetch=%b required 1 1", count_rd(t0, cyc), rd_log[k+1]);
        end
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (line_log[s+i] !== exp_bit(8'hA5, i / CPB)) begin
                errors++;
                $display("FAIL single_line cycle %0d line=%b required %b", i, line_log[s+i], exp_bit(8'hA5, i / CPB));
            end
        end
        checks++;
        if (count_done(t0, cyc) != 1 || done_log[s+FL-1] !== 1'b1) begin
            errors++;
            $display("FAIL single_done count=%0d at_last_stop=%b required 1 1", count_done(t0, cyc), done_log[s+FL-1]);
        end
        checks++;
        if (act_log[k] !== 1'b0 || act_log[k+1] !== 1'b1 || act_log[s+FL-1] !== 1'b1 || act_log[s+FL] !== 1'b0) begin
            errors++;
            $display("FAIL single_active edges=%b%b%b%b required 0110", act_log[k], act_log[k+1], act_log[s+FL-1], act_log[s+FL]);
        end
        eb = exp_q.pop_front();
        checks++;
        if (decode(s) !== eb) begin
            errors++;
            $display("FAIL single_decode got %h required %h", decode(s), eb);
        end
    endtask

    task automatic test_back_to_back;
        int t0, s, s_prev, n, last_rd, rdc;
        logic all_high;
        logic [7:0] eb;
        @(negedge clk);
        t0 = cyc;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        repeat (3 * (FL + 3) + 15) @(negedge clk);
        rdc = 0;
        last_rd = -1;
        for (int k = t0; k < cyc; k++) begin
            if (rd_log[k] === 1'b1) begin
                if (last_rd >= 0) begin
                    checks++;
                    if (k - last_rd != FL + 3) begin
                        errors++;
                        $display("FAIL b2b_read_spacing got %0d required %0d", k - last_rd, FL + 3);
                    end
                end
                last_rd = k;
                rdc++;
            end
        end
        checks++;
        if (rdc != 3) begin
            errors++;
            $display("FAIL b2b_read_count got %0d required 3", rdc);
        end
        s_prev = -1;
        n = t0;
        for (int f = 0; f < 3; f++) begin
            s = find_start(n, cyc - FL);
            checks++;
            if (s < 0) begin
                errors++;
                $display("FAIL b2b_frame_missing frame %0d not found, required present", f);
                break;
            end
            eb = exp_q.pop_front();
            if (decode(s) !== eb) begin
                errors++;
                $display("FAIL b2b_decode frame %0d got %h required %h", f, decode(s), eb);
            end
            if (s_prev >= 0) begin
                all_high = 1'b1;
                for (int k = s_prev + FL; k < s; k++) if (line_log[k] !== 1'b1) all_high = 1'b0;
                checks++;
                if (s - (s_prev + FL) != 3 || !all_high) begin
                    errors++;
                    $display("FAIL b2b_gap frame %0d gap=%0d high=%b required 3 1", f, s - (s_prev + FL), all_high);
                end
            end
            s_prev = s;
            n = s + FL;
        end
    endtask

    task automatic test_enable_gating;
        int s, t1, n;
        logic all_high;
        logic [7:0] eb;
        @(negedge clk);
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        wait_line_low(20, s);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL gate_start no start bit within 20 cycles, required one");
            s = cyc;
        end
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
        repeat (FL + 40) @(negedge clk);
        eb = exp_q.pop_front();
        checks++;
        if (decode(s) !== eb || line_log[s+FL-1] !== 1'b1) begin
            errors++;
            $display("FAIL gate_frame_complete got %h stop=%b required %h 1", decode(s), line_log[s+FL-1], eb);
        end
        checks++;
        if (count_rd(s, cyc) != 0) begin
            errors++;
            $display("FAIL gate_no_read reads=%0d required 0", count_rd(s, cyc));
        end
        all_high = 1'b1;
        for (int k = s + FL; k < cyc; k++) if (line_log[k] !== 1'b1) all_high = 1'b0;
        checks++;
        if (!all_high || tx_active !== 1'b0) begin
            errors++;
            $display("FAIL gate_idle high=%b active=%b required 1 0", all_high, tx_active);
        end
        t1 = cyc;
        tx_en = 1'b1;
        repeat (2 * (FL + 3) + 15) @(negedge clk);
        checks++;
        if (count_rd(t1, cyc) != 2) begin
            errors++;
            $display("FAIL gate_resume_reads got %0d required 2", count_rd(t1, cyc));
        end
        n = t1;
        for (int f = 0; f < 2; f++) begin
            s = find_start(n, cyc - FL);
            checks++;
            if (s < 0) begin
                errors++;
                $display("FAIL gate_resume_frame frame %0d not found, required present", f);
                break;
            end
            eb = exp_q.pop_front();
            if (decode(s) !== eb) begin
                errors++;
                $display("FAIL gate_resume_decode frame %0d got %h required %h", f, decode(s), eb);
            end
            n = s + FL;
        end
    endtask

    task automatic test_mid_reset;
        int s, t1;
        logic [7:0] eb;
        @(negedge clk);
        push_byte(8'h81);
        push_byte(8'h5A);
        wait_line_low(20, s);
        checks++;
        if (s < 0) begin
            errors++;
            $display("FAIL midrst_start no start bit within 20 cycles, required one");
        end
        repeat (CPB * 5 + 1) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b0) begin
            errors++;
            $display("FAIL midrst_bit4 line=%b required 0", tx_serial);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async serial=%b active=%b rd=%b required 1 0 0", tx_serial, tx_active, rd_en);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        eb = exp_q.pop_front();
        t1 = cyc;
        repeat (FL + 20) @(negedge clk);
        checks++;
        if (count_rd(t1, cyc) != 1) begin
            errors++;
            $display("FAIL midrst_reads got %0d required 1", count_rd(t1, cyc));
        end
        s = find_start(t1, cyc - FL);
        eb = exp_q.pop_front();
        checks++;
        if (s < 0 || decode(s) !== eb) begin
            errors++;
            $display("FAIL midrst_next_byte start=%0d got %h required %h", s, (s < 0) ? 8'hxx : decode(s), eb);
        end
    endtask

    task automatic test_frame_format;
        int s, n, d;
        logic [7:0] eb;
        @(negedge clk);
        n = cyc;
        push_byte(8'h07);
        push_byte(8'h03);
        repeat (2 * (FL + 3) + 15) @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            s = find_start(n, cyc - FL);
            checks++;
            if (s < 0) begin
                errors++;
                $display("FAIL fmt_frame frame %0d not found, required present", f);
                break;
            end
            eb = exp_q.pop_front();
            if (decode(s) !== eb) begin
                errors++;
                $display("FAIL fmt_decode frame %0d got %h required %h", f, decode(s), eb);
            end
            checks++;
            if (line_log[s + 9*CPB + CPB/2] !== exp_bit(eb, 9)) begin
                errors++;
                $display("FAIL fmt_bit9 byte %h line=%b required %b", eb, line_log[s + 9*CPB + CPB/2], exp_bit(eb, 9));
            end
            d = -1;
            for (int k = s; k < s + FL + 8; k++) if (d < 0 && done_log[k] === 1'b1) d = k;
            checks++;
            if (d - s + 1 != FL) begin
                errors++;
                $display("FAIL fmt_length byte %h frame_cycles=%0d required %0d", eb, d - s + 1, FL);
            end
            n = s + FL;
        end
    endtask

    task automatic test_random;
        int t0, s, n, nf, rdc;
        logic [7:0] eb;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            push_byte(8'($urandom_range(0, 255)));
        end
        repeat (6 * (FL + 3) + 20) @(negedge clk);
        rdc = count_rd(t0, cyc);
        checks++;
        if (rdc != 6) begin
            errors++;
            $display("FAIL rand_reads got %0d required 6", rdc);
        end
        n = t0;
        nf = 0;
        for (int f = 0; f < 6; f++) begin
            s = find_start(n, cyc - FL);
            if (s < 0) break;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (decode(s) !== eb || line_log[s + FL - 1] !== 1'b1) begin
                errors++;
                $display("FAIL rand_decode frame %0d got %h stop=%b required %h 1", f, decode(s), line_log[s+FL-1], eb);
            end
            n = s + FL;
            nf++;
        end
        checks++;
        if (nf != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_frames decoded=%0d left=%0d required 6 0", nf, exp_q.size());
        end
        checks++;
        if (underflow != 0) begin
            errors++;
            $display("FAIL no_underflow reads_on_empty=%0d required 0", underflow);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_enable_gating;
        test_mid_reset;
        test_frame_format;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
